// File: rtl/mastermind_turn_tracker.sv
// -----------------------------------------------------------------------------
// mastermind_turn_tracker
//
// Purpose:
//   Sits downstream of the peg-scoring datapath. It consumes each scored guess
//   (red, white, guess), counts turns, decides win or loss, and keeps a history
//   of every scored guess for the display. It also tells the upstream control
//   FSM whether further guesses are accepted.
//
// Ports:
//   clk           clock
//   resetn        synchronous, active-low reset
//   result_valid  1-cycle strobe: red/white/guess are valid this cycle
//   red, white    exact-position / colour-only match counts
//   guess         the guess that was scored (PEGS*COLOR_W bits)
//   new_game      1-cycle strobe: restart game and clear history
//   hist_sel      history entry to read (0 = first guess of the game)
//   accept_guess  1 while in PLAY
//   turn_count    number of scored guesses this game (saturates at MAX_TURNS)
//   win, lose     game outcome flags, held until new_game or reset
//   err           sticky flag: a malformed result was seen this game
//   last_red/last_white  scores of the most recent accepted result
//   hist_valid    hist_sel < turn_count
//   hist_guess/hist_red/hist_white  stored entry at hist_sel, 0 when invalid
// -----------------------------------------------------------------------------
module mastermind_turn_tracker #(
  parameter int MAX_TURNS = 8,
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      result_valid,
  input  logic [2:0]                red,
  input  logic [2:0]                white,
  input  logic [PEGS*COLOR_W-1:0]   guess,
  input  logic                      new_game,
  input  logic [3:0]                hist_sel,
  output logic                      accept_guess,
  output logic [3:0]                turn_count,
  output logic                      win,
  output logic                      lose,
  output logic                      err,
  output logic [2:0]                last_red,
  output logic [2:0]                last_white,
  output logic                      hist_valid,
  output logic [PEGS*COLOR_W-1:0]   hist_guess,
  output logic [2:0]                hist_red,
  output logic [2:0]                hist_white
);

  localparam int GW    = PEGS * COLOR_W;
  localparam int IDX_W = (MAX_TURNS > 1) ? $clog2(MAX_TURNS) : 1;

  localparam logic [2:0] PEGS_3 = 3'(PEGS);
  localparam logic [3:0] PEGS_4 = 4'(PEGS);
  localparam logic [3:0] MAX_4  = 4'(MAX_TURNS);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_t;

  state_t state;

  // History register file, one entry per scored guess.
  logic [GW-1:0] mem_guess [MAX_TURNS];
  logic [2:0]    mem_red   [MAX_TURNS];
  logic [2:0]    mem_white [MAX_TURNS];

  // Sum is done at 4 bits so 7+7 cannot wrap into a "legal" value.
  logic [3:0]       rw_sum;
  logic             malformed;
  logic [3:0]       turn_next;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign rw_sum    = {1'b0, red} + {1'b0, white};
  assign malformed = (red > PEGS_3) || (white > PEGS_3) || (rw_sum > PEGS_4);
  assign turn_next = turn_count + 4'd1;
  // In PLAY turn_count < MAX_TURNS, so the low bits address a valid entry.
  assign wr_idx    = turn_count[IDX_W-1:0];
  assign rd_idx    = hist_sel[IDX_W-1:0];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // behaviour between the state, counter and history writes.
  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      state        <= PLAY;
      accept_guess <= 1'b1;
      win          <= 1'b0;
      lose         <= 1'b0;
      turn_count   <= 4'd0;
      err          <= 1'b0;
      last_red     <= 3'd0;
      last_white   <= 3'd0;
      // NOTE: the history is cleared explicitly rather than left stale; the
      // display may read it directly and a new game must start from zeros.
      for (int i = 0; i < MAX_TURNS; i++) begin
        mem_guess[i] <= '0;
        mem_red[i]   <= 3'd0;
        mem_white[i] <= 3'd0;
      end
    end else if (result_valid && state == PLAY) begin
      if (malformed) begin
        err <= 1'b1;
      end else begin
        mem_guess[wr_idx] <= guess;
        mem_red[wr_idx]   <= red;
        mem_white[wr_idx] <= white;
        turn_count        <= turn_next;
        last_red          <= red;
        last_white        <= white;
        // Win is tested first so a perfect score on the last turn still wins.
        if (red == PEGS_3) begin
          state        <= WIN;
          accept_guess <= 1'b0;
          win          <= 1'b1;
        end else if (turn_next == MAX_4) begin
          state        <= LOSE;
          accept_guess <= 1'b0;
          lose         <= 1'b1;
        end
      end
    end
  end

  // Combinational history read, forced to zero outside the filled range.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would infer a latch.
  always_comb begin
    hist_valid = (hist_sel < turn_count);
    hist_guess = '0;
    hist_red   = 3'd0;
    hist_white = 3'd0;
    if (hist_valid) begin
      hist_guess = mem_guess[rd_idx];
      hist_red   = mem_red[rd_idx];
      hist_white = mem_white[rd_idx];
    end
  end

endmodule

// File: tb/tb_mastermind_turn_tracker.sv
// -----------------------------------------------------------------------------
// tb_mastermind_turn_tracker
//
// Directed testbench for mastermind_turn_tracker (MAX_TURNS=8, PEGS=4,
// COLOR_W=3). Inputs are driven on the falling edge; outputs are sampled on
// the falling edge after the capturing rising edge.
// -----------------------------------------------------------------------------
module tb_mastermind_turn_tracker;

  logic        clk;
  logic        resetn;
  logic        result_valid;
  logic [2:0]  red;
  logic [2:0]  white;
  logic [11:0] guess;
  logic        new_game;
  logic [3:0]  hist_sel;
  logic        accept_guess;
  logic [3:0]  turn_count;
  logic        win;
  logic        lose;
  logic        err;
  logic [2:0]  last_red;
  logic [2:0]  last_white;
  logic        hist_valid;
  logic [11:0] hist_guess;
  logic [2:0]  hist_red;
  logic [2:0]  hist_white;

  int n_checks = 0;
  int n_errors = 0;

  mastermind_turn_tracker #(
    .MAX_TURNS(8),
    .PEGS     (4),
    .COLOR_W  (3)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .result_valid(result_valid),
    .red         (red),
    .white       (white),
    .guess       (guess),
    .new_game    (new_game),
    .hist_sel    (hist_sel),
    .accept_guess(accept_guess),
    .turn_count  (turn_count),
    .win         (win),
    .lose        (lose),
    .err         (err),
    .last_red    (last_red),
    .last_white  (last_white),
    .hist_valid  (hist_valid),
    .hist_guess  (hist_guess),
    .hist_red    (hist_red),
    .hist_white  (hist_white)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] r, input logic [2:0] w, input logic [11:0] g);
    @(negedge clk);
    result_valid = 1'b1;
    red          = r;
    white        = w;
    guess        = g;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic acc, input logic [3:0] tc,
                              input logic w, input logic l, input logic e);
    check({tag, ".accept"}, 32'(accept_guess), 32'(acc));
    check({tag, ".turns"},  32'(turn_count),   32'(tc));
    check({tag, ".win"},    32'(win),          32'(w));
    check({tag, ".lose"},   32'(lose),         32'(l));
    check({tag, ".err"},    32'(err),          32'(e));
  endtask

  task automatic check_hist(input string tag, input logic [3:0] sel, input logic v,
                            input logic [11:0] g, input logic [2:0] r, input logic [2:0] w);
    hist_sel = sel;
    #1;
    check({tag, ".hvalid"}, 32'(hist_valid), 32'(v));
    check({tag, ".hguess"}, 32'(hist_guess), 32'(g));
    check({tag, ".hred"},   32'(hist_red),   32'(r));
    check({tag, ".hwhite"}, 32'(hist_white), 32'(w));
  endtask

  initial begin
    resetn       = 1'b0;
    result_valid = 1'b0;
    red          = 3'd0;
    white        = 3'd0;
    guess        = 12'd0;
    new_game     = 1'b0;
    hist_sel     = 4'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check_status("rst", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst.last_red", 32'(last_red), 0);
    check_hist("rst.h0", 4'd0, 1'b0, 12'h000, 3'd0, 3'd0);

    // Scenario 1: (1,2), (0,1), (4,0) -> win on turn 3
    send(3'd1, 3'd2, 12'h123);
    check_status("s1.t1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    check("s1.t1.last_white", 32'(last_white), 2);
    send(3'd0, 3'd1, 12'h456);
    send(3'd4, 3'd0, 12'h789);
    check_status("s1.t3", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    check("s1.last_red", 32'(last_red), 4);
    check_hist("s1.h2", 4'd2, 1'b1, 12'h789, 3'd4, 3'd0);
    check_hist("s1.h0", 4'd0, 1'b1, 12'h123, 3'd1, 3'd2);
    check_hist("s1.h1", 4'd1, 1'b1, 12'h456, 3'd0, 3'd1);
    check_hist("s1.h3", 4'd3, 1'b0, 12'h000, 3'd0, 3'd0);
    // Result in WIN is ignored, including a malformed one
    send(3'd2, 3'd1, 12'hAAA);
    send(3'd5, 3'd0, 12'hBBB);
    check_status("s1.ign", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    check("s1.ign.last_red", 32'(last_red), 4);

    // Scenario 5: new_game and result_valid together while in WIN
    @(negedge clk);
    new_game     = 1'b1;
    result_valid = 1'b1;
    red          = 3'd2;
    white        = 3'd2;
    guess        = 12'hCCC;
    @(negedge clk);
    new_game     = 1'b0;
    result_valid = 1'b0;
    check_status("s5", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("s5.last_red", 32'(last_red), 0);
    check_hist("s5.h0", 4'd0, 1'b0, 12'h000, 3'd0, 3'd0);

    // Scenario 2: 8 misses -> LOSE after the 8th, 9th ignored
    for (int i = 0; i < 7; i++) send(3'd1, 3'd0, 12'(i + 1));
    check_status("s2.t7", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    send(3'd1, 3'd0, 12'h0F8);
    check_status("s2.t8", 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    send(3'd2, 3'd1, 12'hFFF);
    check_status("s2.t9", 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    check("s2.t9.last_red", 32'(last_red), 1);
    check_hist("s2.h7", 4'd7, 1'b1, 12'h0F8, 3'd1, 3'd0);
    check_hist("s2.h8", 4'd8, 1'b0, 12'h000, 3'd0, 3'd0);

    // Scenario 3: 7 misses then red=PEGS on the last turn -> WIN
    start_game();
    for (int i = 0; i < 7; i++) send(3'd0, 3'd0, 12'h100);
    send(3'd4, 3'd0, 12'h777);
    check_status("s3", 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

    // Scenario 4: malformed (3,2), then valid (2,1) lands at entry 0
    start_game();
    send(3'd3, 3'd2, 12'h321);
    check_status("s4.bad", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    check_hist("s4.bad.h0", 4'd0, 1'b0, 12'h000, 3'd0, 3'd0);
    send(3'd2, 3'd1, 12'h210);
    check_status("s4.ok", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    check_hist("s4.ok.h0", 4'd0, 1'b1, 12'h210, 3'd2, 3'd1);
    // white alone out of range is malformed; sum exactly PEGS is legal
    send(3'd0, 3'd5, 12'h050);
    check("s4.w5.turns", 32'(turn_count), 1);
    send(3'd2, 3'd2, 12'h220);
    check("s4.sum4.turns", 32'(turn_count), 2);
    check("s4.sum4.last_white", 32'(last_white), 2);

    // Scenario 6: 5 turns then a one-cycle reset
    start_game();
    for (int i = 0; i < 5; i++) send(3'd1, 3'd1, 12'(16 * i + 3));
    check_status("s6.pre", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_status("s6.rst", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    check("s6.rst.last_red",   32'(last_red),   0);
    check("s6.rst.last_white", 32'(last_white), 0);
    for (int s = 0; s < 16; s++) begin
      check_hist($sformatf("s6.h%0d", s), 4'(s), 1'b0, 12'h000, 3'd0, 3'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
